mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_slot.sv | 27 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding, port IDs,
// pending-slot payload layout and the grant selection helper.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MEM   = 1'b1;

  localparam int PAYLOAD_W = 69;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } payload_t;

  // On a tie, round-robin picks the port that was not granted last.
  function automatic logic pick_port(input logic fetch_valid, input logic mem_valid,
                                     input logic fair, input logic last_grant);
    if (fetch_valid && mem_valid)
      return fair ? ~last_grant : PORT_MEM;
    else if (mem_valid)
      return PORT_MEM;
    else
      return PORT_FETCH;
  endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request slot: valid flag plus latched payload. A set while
// already valid is dropped, except in the clearing cycle where set wins.
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic                 clr,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (set && (!valid || clr)) begin
      valid   <= 1'b1;
      payload <= payload_in;
    end else if (clr) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, mem) arbiter onto a single downstream memory interface,
// with at most one downstream transaction outstanding.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,

  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,

  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,

  output logic        busy
);

  state_t   state_reg;
  logic     last_grant_reg;
  logic     next_port;
  logic     rsp_accept;
  logic [1:0] slot_set;
  logic [1:0] slot_clr;
  logic [1:0] slot_valid;
  payload_t slot_in [2];
  payload_t slot_q  [2];

  assign slot_set = {mem_request_enable, fetch_request_enable};
  assign slot_in[PORT_FETCH] = '{mode: freq_mode, addr: freq_addr, wdata: freq_wdata, wstrb: freq_wstrb};
  assign slot_in[PORT_MEM]   = '{mode: mreq_mode, addr: mreq_addr, wdata: mreq_wdata, wstrb: mreq_wstrb};

  // Responses only count while a transaction is outstanding.
  assign rsp_accept = (state_reg == WAIT) && response_enable;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_clr[gi] = rsp_accept && (last_grant_reg == 1'(gi));

      mem_arb_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .set        (slot_set[gi]),
        .clr        (slot_clr[gi]),
        .payload_in (slot_in[gi]),
        .valid      (slot_valid[gi]),
        .payload    (slot_q[gi])
      );
    end
  endgenerate

  assign next_port = pick_port(slot_valid[PORT_FETCH], slot_valid[PORT_MEM],
                               FAIR != 0, last_grant_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg             <= IDLE;
      last_grant_reg        <= PORT_FETCH;
      request_enable        <= 1'b0;
      busy                  <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      req_mode              <= 1'b0;
      req_addr              <= 32'h0;
      req_wdata             <= 32'h0;
      req_wstrb             <= 4'h0;
      fresp_data            <= 32'h0;
      mresp_data            <= 32'h0;
    end else begin
      request_enable        <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|slot_valid) begin
            state_reg      <= WAIT;
            last_grant_reg <= next_port;
            request_enable <= 1'b1;
            busy           <= 1'b1;
            req_mode       <= slot_q[next_port].mode;
            req_addr       <= slot_q[next_port].addr;
            req_wdata      <= slot_q[next_port].wdata;
            req_wstrb      <= slot_q[next_port].wstrb;
          end
        end
        WAIT: begin
          // req_* are left untouched here so they stay stable until the response.
          if (response_enable) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            if (last_grant_reg == PORT_MEM) begin
              mem_response_enable <= 1'b1;
              mresp_data          <= resp_data;
            end else begin
              fetch_response_enable <= 1'b1;
              fresp_data            <= resp_data;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table on the FAIR=1
// instance plus hand sequences for contention (FAIR=1 vs FAIR=0) and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fe = 1'b0, fm = 1'b0, me = 1'b0, mm = 1'b0, re = 1'b0;
  logic [31:0] fa = '0, fw = '0, ma = '0, mw = '0, rd = '0;
  logic [3:0]  fs = '0, ms = '0;

  logic        fr1, mr1, rq1, rm1, bz1;
  logic [31:0] fd1, md1, ra1, rw1;
  logic [3:0]  rs1;
  logic        fr0, mr0, rq0, rm0, bz0;
  logic [31:0] fd0, md0, ra0, rw0;
  logic [3:0]  rs0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fe), .freq_mode(fm), .freq_addr(fa), .freq_wdata(fw), .freq_wstrb(fs),
    .fetch_response_enable(fr1), .fresp_data(fd1),
    .mem_request_enable(me), .mreq_mode(mm), .mreq_addr(ma), .mreq_wdata(mw), .mreq_wstrb(ms),
    .mem_response_enable(mr1), .mresp_data(md1),
    .request_enable(rq1), .req_mode(rm1), .req_addr(ra1), .req_wdata(rw1), .req_wstrb(rs1),
    .response_enable(re), .resp_data(rd), .busy(bz1)
  );

  mem_arbiter #(.FAIR(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fe), .freq_mode(fm), .freq_addr(fa), .freq_wdata(fw), .freq_wstrb(fs),
    .fetch_response_enable(fr0), .fresp_data(fd0),
    .mem_request_enable(me), .mreq_mode(mm), .mreq_addr(ma), .mreq_wdata(mw), .mreq_wstrb(ms),
    .mem_response_enable(mr0), .mresp_data(md0),
    .request_enable(rq0), .req_mode(rm0), .req_addr(ra0), .req_wdata(rw0), .req_wstrb(rs0),
    .response_enable(re), .resp_data(rd), .busy(bz0)
  );

  typedef struct {
    logic fe; logic [31:0] fa;
    logic me; logic mm; logic [31:0] ma; logic [31:0] mw; logic [3:0] ms;
    logic re; logic [31:0] rd;
    logic x_req; logic x_busy; logic [31:0] x_addr; logic x_mode; logic [31:0] x_wdata; logic [3:0] x_wstrb;
    logic x_fr; logic [31:0] x_fd; logic x_mr; logic [31:0] x_md;
  } vec_t;

  vec_t vec [34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fe = 0; fm = 0; fa = '0; fw = '0; fs = '0;
    me = 0; mm = 0; ma = '0; mw = '0; ms = '0;
    re = 0; rd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // fe fa | me mm ma mw ms | re rd | x_req x_busy x_addr x_mode x_wdata x_wstrb | x_fr x_fd x_mr x_md
    vec[0]  = '{1, 32'h1000, 0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h0,0,0};
    vec[1]  = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h0,0,0};
    vec[2]  = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h1000,0,0,0, 0,32'h0,0,0};
    vec[3]  = '{0, 0,        0,0,0,0,0, 0,0,            0,1,32'h1000,0,0,0, 0,32'h0,0,0};
    vec[4]  = '{0, 0,        0,0,0,0,0, 0,0,            0,1,32'h1000,0,0,0, 0,32'h0,0,0};
    vec[5]  = '{0, 0,        0,0,0,0,0, 1,32'hDEADBEEF, 0,1,32'h1000,0,0,0, 0,32'h0,0,0};
    vec[6]  = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    1,32'hDEADBEEF,0,0};
    vec[7]  = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'hDEADBEEF,0,0};
    vec[8]  = '{1, 32'h100,  1,1,32'h200,32'h55,4'hF, 0,0, 0,0,32'h0,0,0,0, 0,32'hDEADBEEF,0,0};
    vec[9]  = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'hDEADBEEF,0,0};
    vec[10] = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h200,1,32'h55,4'hF, 0,32'hDEADBEEF,0,0};
    vec[11] = '{0, 0,        0,0,0,0,0, 1,32'h1111,     0,1,32'h200,1,32'h55,4'hF, 0,32'hDEADBEEF,0,0};
    vec[12] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'hDEADBEEF,1,32'h1111};
    vec[13] = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h100,0,0,0,  0,32'hDEADBEEF,0,32'h1111};
    vec[14] = '{0, 0,        0,0,0,0,0, 1,32'h2222,     0,1,32'h100,0,0,0,  0,32'hDEADBEEF,0,32'h1111};
    vec[15] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    1,32'h2222,0,32'h1111};
    vec[16] = '{1, 32'h100,  0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h2222,0,32'h1111};
    vec[17] = '{1, 32'h300,  0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h2222,0,32'h1111};
    vec[18] = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h100,0,0,0,  0,32'h2222,0,32'h1111};
    vec[19] = '{0, 0,        0,0,0,0,0, 0,0,            0,1,32'h100,0,0,0,  0,32'h2222,0,32'h1111};
    vec[20] = '{0, 0,        0,0,0,0,0, 1,32'h3333,     0,1,32'h100,0,0,0,  0,32'h2222,0,32'h1111};
    vec[21] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    1,32'h3333,0,32'h1111};
    vec[22] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h3333,0,32'h1111};
    vec[23] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h3333,0,32'h1111};
    vec[24] = '{1, 32'h400,  0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h3333,0,32'h1111};
    vec[25] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h3333,0,32'h1111};
    vec[26] = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h400,0,0,0,  0,32'h3333,0,32'h1111};
    vec[27] = '{1, 32'h500,  0,0,0,0,0, 1,32'h4444,     0,1,32'h400,0,0,0,  0,32'h3333,0,32'h1111};
    vec[28] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    1,32'h4444,0,32'h1111};
    vec[29] = '{0, 0,        0,0,0,0,0, 0,0,            1,1,32'h500,0,0,0,  0,32'h4444,0,32'h1111};
    vec[30] = '{0, 0,        0,0,0,0,0, 1,32'h5555,     0,1,32'h500,0,0,0,  0,32'h4444,0,32'h1111};
    vec[31] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    1,32'h5555,0,32'h1111};
    vec[32] = '{0, 0,        0,0,0,0,0, 1,32'h9999,     0,0,32'h0,0,0,0,    0,32'h5555,0,32'h1111};
    vec[33] = '{0, 0,        0,0,0,0,0, 0,0,            0,0,32'h0,0,0,0,    0,32'h5555,0,32'h1111};

    // Reset state, sampled while rst is held.
    idle_inputs();
    #2;
    chk("rst request_enable", 32'(rq1), 32'h0);
    chk("rst busy", 32'(bz1), 32'h0);
    chk("rst fetch_response_enable", 32'(fr1), 32'h0);
    chk("rst mem_response_enable", 32'(mr1), 32'h0);
    chk("rst req_addr", ra1, 32'h0);
    chk("rst req_wdata", rw1, 32'h0);
    chk("rst req_wstrb", 32'(rs1), 32'h0);
    chk("rst req_mode", 32'(rm1), 32'h0);
    chk("rst fresp_data", fd1, 32'h0);
    chk("rst mresp_data", md1, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Vector table: check cycle i outputs, then drive cycle i inputs.
    for (int i = 0; i < 34; i++) begin
      chk($sformatf("vec%0d request_enable", i), 32'(rq1), 32'(vec[i].x_req));
      chk($sformatf("vec%0d busy", i), 32'(bz1), 32'(vec[i].x_busy));
      if (vec[i].x_busy) begin
        chk($sformatf("vec%0d req_addr", i), ra1, vec[i].x_addr);
        chk($sformatf("vec%0d req_mode", i), 32'(rm1), 32'(vec[i].x_mode));
        chk($sformatf("vec%0d req_wdata", i), rw1, vec[i].x_wdata);
        chk($sformatf("vec%0d req_wstrb", i), 32'(rs1), 32'(vec[i].x_wstrb));
      end
      chk($sformatf("vec%0d fetch_response_enable", i), 32'(fr1), 32'(vec[i].x_fr));
      chk($sformatf("vec%0d fresp_data", i), fd1, vec[i].x_fd);
      chk($sformatf("vec%0d mem_response_enable", i), 32'(mr1), 32'(vec[i].x_mr));
      chk($sformatf("vec%0d mresp_data", i), md1, vec[i].x_md);
      fe = vec[i].fe; fa = vec[i].fa; fm = 1'b0; fw = '0; fs = '0;
      me = vec[i].me; mm = vec[i].mm; ma = vec[i].ma; mw = vec[i].mw; ms = vec[i].ms;
      re = vec[i].re; rd = vec[i].rd;
      step();
    end
    idle_inputs();

    // Contention: both ports kept pending by re-requesting in each response cycle.
    begin
      logic [31:0] exp1_addr [4];
      logic        exp1_mem  [4];
      logic [31:0] exp0_addr [4];
      exp1_addr = '{32'hA00, 32'hF00, 32'hA01, 32'hF02};
      exp1_mem  = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp0_addr = '{32'hA00, 32'hA01, 32'hA02, 32'hA03};
      do_reset();
      fe = 1; fa = 32'hF00; me = 1; ma = 32'hA00;
      step();
      idle_inputs();
      step();
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rr%0d fair request_enable", g), 32'(rq1), 32'h1);
        chk($sformatf("rr%0d fair req_addr", g), ra1, exp1_addr[g]);
        chk($sformatf("rr%0d fixed request_enable", g), 32'(rq0), 32'h1);
        chk($sformatf("rr%0d fixed req_addr", g), ra0, exp0_addr[g]);
        re = 1; rd = 32'h7000 + 32'(g);
        fe = 1; fa = 32'hF00 + 32'(g + 1);
        me = 1; ma = 32'hA00 + 32'(g + 1);
        step();
        idle_inputs();
        chk($sformatf("rr%0d fair mem_response_enable", g), 32'(mr1), 32'(exp1_mem[g]));
        chk($sformatf("rr%0d fair fetch_response_enable", g), 32'(fr1), 32'(!exp1_mem[g]));
        chk($sformatf("rr%0d fair resp data", g), exp1_mem[g] ? md1 : fd1, 32'h7000 + 32'(g));
        chk($sformatf("rr%0d fixed mem_response_enable", g), 32'(mr0), 32'h1);
        chk($sformatf("rr%0d fixed fetch_response_enable", g), 32'(fr0), 32'h0);
        chk($sformatf("rr%0d fixed mresp_data", g), md0, 32'h7000 + 32'(g));
        step();
      end
    end

    // Reset while a transaction is outstanding, then a stray response.
    do_reset();
    fe = 1; fa = 32'h600;
    step();
    idle_inputs();
    step();
    chk("rw request_enable", 32'(rq1), 32'h1);
    chk("rw req_addr", ra1, 32'h600);
    step();
    chk("rw busy before reset", 32'(bz1), 32'h1);
    rst = 1'b1;
    #1;
    chk("rw async busy", 32'(bz1), 32'h0);
    chk("rw async req_addr", ra1, 32'h0);
    chk("rw async fresp_data", fd1, 32'h0);
    chk("rw async mresp_data", md1, 32'h0);
    chk("rw async fixed mresp_data", md0, 32'h0);
    step();
    rst = 1'b0;
    re = 1; rd = 32'hBAD0BAD0;
    step();
    idle_inputs();
    chk("rw stray fetch_response_enable", 32'(fr1), 32'h0);
    chk("rw stray mem_response_enable", 32'(mr1), 32'h0);
    chk("rw stray busy", 32'(bz1), 32'h0);
    chk("rw stray request_enable", 32'(rq1), 32'h0);
    chk("rw stray fresp_data", fd1, 32'h0);
    me = 1; mm = 1; ma = 32'h700; mw = 32'h77; ms = 4'h3;
    step();
    idle_inputs();
    chk("rw next not early", 32'(rq1), 32'h0);
    step();
    chk("rw next request_enable", 32'(rq1), 32'h1);
    chk("rw next req_addr", ra1, 32'h700);
    chk("rw next req_mode", 32'(rm1), 32'h1);
    chk("rw next req_wdata", rw1, 32'h77);
    chk("rw next req_wstrb", 32'(rs1), 32'h3);
    re = 1; rd = 32'h8888;
    step();
    idle_inputs();
    chk("rw next mem_response_enable", 32'(mr1), 32'h1);
    chk("rw next mresp_data", md1, 32'h8888);
    chk("rw next fetch_response_enable", 32'(fr1), 32'h0);
    chk("rw next busy", 32'(bz1), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
